// File: rtl/jarvis_alu_pkg.sv
// Jarvis ALU control stage: shared encodings.
// ALU_Op classes, funct/opcode values, control codes, FSM states.
package jarvis_alu_pkg;

  localparam logic [1:0] ALUOP_NONE = 2'd0;
  localparam logic [1:0] ALUOP_R    = 2'd1;
  localparam logic [1:0] ALUOP_I    = 2'd2;
  localparam logic [1:0] ALUOP_RSV  = 2'd3;

  localparam int F_ADD  = 0;
  localparam int F_SUB  = 1;
  localparam int F_MULT = 2;
  localparam int F_DIV  = 3;
  localparam int F_MOD  = 4;
  localparam int F_AND  = 5;
  localparam int F_OR   = 6;
  localparam int F_XOR  = 7;
  localparam int F_NOT  = 8;

  localparam int OPC_MOVE = 'h03;
  localparam int OPC_ADDI = 'h05;
  localparam int OPC_SUBI = 'h06;
  localparam int OPC_SHLI = 'h07;
  localparam int OPC_SHRI = 'h08;
  localparam int OPC_ANDI = 'h0A;
  localparam int OPC_ORI  = 'h0C;
  localparam int OPC_BEQ  = 'h0E;
  localparam int OPC_BNE  = 'h0F;
  localparam int OPC_BLT  = 'h10;
  localparam int OPC_BGT  = 'h11;
  localparam int OPC_BLE  = 'h12;
  localparam int OPC_BGE  = 'h13;
  localparam int OPC_SLT  = 'h14;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_MULT = 5'd2;
  localparam logic [4:0] ALU_DIV  = 5'd3;
  localparam logic [4:0] ALU_MOD  = 5'd4;
  localparam logic [4:0] ALU_MOVE = 5'd5;
  localparam logic [4:0] ALU_AND  = 5'd6;
  localparam logic [4:0] ALU_OR   = 5'd7;
  localparam logic [4:0] ALU_XOR  = 5'd8;
  localparam logic [4:0] ALU_NOT  = 5'd9;
  localparam logic [4:0] ALU_SHL  = 5'd10;
  localparam logic [4:0] ALU_SHR  = 5'd11;
  localparam logic [4:0] ALU_BEQ  = 5'd12;
  localparam logic [4:0] ALU_BNE  = 5'd13;
  localparam logic [4:0] ALU_BLT  = 5'd14;
  localparam logic [4:0] ALU_BGT  = 5'd15;
  localparam logic [4:0] ALU_BLE  = 5'd16;
  localparam logic [4:0] ALU_BGE  = 5'd17;
  localparam logic [4:0] ALU_SLT  = 5'd18;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OUT,
    S_MC_WAIT
  } state_e;

endpackage

// File: rtl/jarvis_alu_decode.sv
// Pure combinational decode of ALU_Op/Op_Code/funct.
// Produces control code, illegal flag and multi-cycle flag.
module jarvis_alu_decode
  import jarvis_alu_pkg::*;
#(
  parameter int OP_W    = 5,
  parameter int FUNCT_W = 5,
  parameter int CTRL_W  = 5
) (
  input  logic [1:0]         alu_op_i,
  input  logic [OP_W-1:0]    op_code_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [CTRL_W-1:0]  code_o,
  output logic               illegal_o,
  output logic               multi_o
);

  logic [31:0] opc;
  logic [31:0] fn;
  logic [4:0]  c;
  logic        ill;

  assign opc = 32'(op_code_i);
  assign fn  = 32'(funct_i);

  always_comb begin
    c   = ALU_ADD;
    ill = 1'b0;
    unique case (alu_op_i)
      ALUOP_NONE: c = ALU_ADD;
      ALUOP_R: begin
        case (fn)
          F_ADD:   c = ALU_ADD;
          F_SUB:   c = ALU_SUB;
          F_MULT:  c = ALU_MULT;
          F_DIV:   c = ALU_DIV;
          F_MOD:   c = ALU_MOD;
          F_AND:   c = ALU_AND;
          F_OR:    c = ALU_OR;
          F_XOR:   c = ALU_XOR;
          F_NOT:   c = ALU_NOT;
          default: ill = 1'b1;
        endcase
      end
      ALUOP_I: begin
        case (opc)
          OPC_MOVE: c = ALU_MOVE;
          OPC_ADDI: c = ALU_ADD;
          OPC_SUBI: c = ALU_SUB;
          OPC_SHLI: c = ALU_SHL;
          OPC_SHRI: c = ALU_SHR;
          OPC_ANDI: c = ALU_AND;
          OPC_ORI:  c = ALU_OR;
          OPC_BEQ:  c = ALU_BEQ;
          OPC_BNE:  c = ALU_BNE;
          OPC_BLT:  c = ALU_BLT;
          OPC_BGT:  c = ALU_BGT;
          OPC_BLE:  c = ALU_BLE;
          OPC_BGE:  c = ALU_BGE;
          OPC_SLT:  c = ALU_SLT;
          default:  ill = 1'b1;
        endcase
      end
      ALUOP_RSV: ill = 1'b1;
    endcase
  end

  assign code_o    = ill ? '0 : CTRL_W'(c);
  assign illegal_o = ill;
  assign multi_o   = (alu_op_i == ALUOP_R) && !ill &&
                     (c == ALU_MULT || c == ALU_DIV || c == ALU_MOD);

endmodule

// File: rtl/jarvis_alu_sequencer.sv
// Decode-to-execute ALU control stage with valid/ready on both sides.
// Multi-cycle ops are handed to an iterative unit with timeout/abort.
module jarvis_alu_sequencer
  import jarvis_alu_pkg::*;
#(
  parameter int OP_W    = 5,
  parameter int FUNCT_W = 5,
  parameter int CTRL_W  = 5,
  parameter int TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         ALU_Op,
  input  logic [OP_W-1:0]    Op_Code,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  ALU_Control,
  output logic               out_illegal,
  output logic               out_timeout,
  output logic               mc_start,
  output logic [CTRL_W-1:0]  mc_op,
  input  logic               mc_done,
  output logic               mc_abort,
  output logic               busy
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [CTRL_W-1:0]   mc_op_q, mc_op_d;
  logic                ill_q, ill_d;
  logic                to_q, to_d;
  logic                start_q, start_d;
  logic                abort_q, abort_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [CTRL_W-1:0]   dec_code;
  logic                dec_ill;
  logic                dec_multi;
  logic                accept;

  jarvis_alu_decode #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W),
    .CTRL_W  (CTRL_W)
  ) u_decode (
    .alu_op_i  (ALU_Op),
    .op_code_i (Op_Code),
    .funct_i   (funct),
    .code_o    (dec_code),
    .illegal_o (dec_ill),
    .multi_o   (dec_multi)
  );

  assign in_ready = !flush &&
    (state_q == S_IDLE || (state_q == S_OUT && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    mc_op_d = mc_op_q;
    ill_d   = ill_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ctrl_d  = '0;
      ill_d   = 1'b0;
      to_d    = 1'b0;
      abort_d = (state_q == S_MC_WAIT);
    end else begin
      unique case (state_q)
        S_IDLE, S_OUT: begin
          if (accept) begin
            to_d = 1'b0;
            if (dec_multi) begin
              state_d = S_MC_WAIT;
              start_d = 1'b1;
              mc_op_d = dec_code;
              cnt_d   = '0;
              ctrl_d  = '0;
              ill_d   = 1'b0;
            end else begin
              state_d = S_OUT;
              ctrl_d  = dec_code;
              ill_d   = dec_ill;
            end
          end else if (state_q == S_OUT && out_ready) begin
            state_d = S_IDLE;
            ctrl_d  = '0;
            ill_d   = 1'b0;
            to_d    = 1'b0;
          end
        end
        S_MC_WAIT: begin
          cnt_d = cnt_q + 1'b1;
          // done takes precedence over a coincident timeout
          if (mc_done) begin
            state_d = S_OUT;
            ctrl_d  = mc_op_q;
            to_d    = 1'b0;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_OUT;
            ctrl_d  = mc_op_q;
            to_d    = 1'b1;
            abort_d = 1'b1;
            cnt_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      mc_op_q <= '0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      mc_op_q <= mc_op_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
      start_q <= start_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = (state_q == S_OUT);
  assign ALU_Control = ctrl_q;
  assign out_illegal = ill_q;
  assign out_timeout = to_q;
  assign mc_start    = start_q;
  assign mc_op       = mc_op_q;
  assign mc_abort    = abort_q;
  assign busy        = (state_q == S_MC_WAIT);

endmodule

// File: tb/tb_jarvis_alu_sequencer.sv
// Directed and randomized checks for jarvis_alu_sequencer.
// Expected words come from a table-driven decode model.
module tb_jarvis_alu_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] ALU_Op;
  logic [4:0] Op_Code;
  logic [4:0] funct;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] ALU_Control;
  logic       out_illegal;
  logic       out_timeout;
  logic       mc_start;
  logic [4:0] mc_op;
  logic       mc_done;
  logic       mc_abort;
  logic       busy;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  int rtab [9] = '{0, 1, 2, 3, 4, 6, 7, 8, 9};
  int itab [int];

  always #5 clock = ~clock;

  jarvis_alu_sequencer #(
    .OP_W(5), .FUNCT_W(5), .CTRL_W(5), .TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALU_Op(ALU_Op), .Op_Code(Op_Code), .funct(funct),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Control(ALU_Control), .out_illegal(out_illegal),
    .out_timeout(out_timeout), .mc_start(mc_start),
    .mc_op(mc_op), .mc_done(mc_done), .mc_abort(mc_abort),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_dec(input int aop, input int opc,
      input int fn, output int code, output bit ill, output bit mul);
    code = 0; ill = 0; mul = 0;
    if (aop == 1) begin
      if (fn <= 8) begin
        code = rtab[fn];
        mul = (code >= 2 && code <= 4);
      end else ill = 1;
    end else if (aop == 2) begin
      if (itab.exists(opc)) code = itab[opc];
      else ill = 1;
    end else if (aop == 3) ill = 1;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int aop, input int opc, input int fn);
    in_valid = 1'b1;
    ALU_Op = 2'(aop);
    Op_Code = 5'(opc);
    funct = 5'(fn);
  endtask

  initial begin
    int code, nb, ns, na, ab_at, to_at, ov_at, exp_code;
    bit ill, mul, pend, exp_ill, ir;
    int seq [3] = '{'h05, 'h0E, 'h14};

    itab['h03] = 5;  itab['h05] = 0;  itab['h06] = 1;
    itab['h07] = 10; itab['h08] = 11; itab['h0A] = 6;
    itab['h0C] = 7;  itab['h0E] = 12; itab['h0F] = 13;
    itab['h10] = 14; itab['h11] = 15; itab['h12] = 16;
    itab['h13] = 17; itab['h14] = 18;

    reset = 1; flush = 0; in_valid = 0; ALU_Op = 0;
    Op_Code = 0; funct = 0; out_ready = 0; mc_done = 0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ctrl", ALU_Control, 0);
    chk("rst_flags", {out_illegal, out_timeout}, 0);
    chk("rst_mc", {mc_start, mc_abort, busy}, 0);
    chk("rst_mc_op", mc_op, 0);
    reset = 0;
    tick();

    // XOR via funct 7
    out_ready = 1;
    drive(1, 0, 7);
    tick();
    in_valid = 0;
    ref_dec(1, 0, 7, code, ill, mul);
    chk("xor_valid", out_valid, 1);
    chk("xor_ctrl", ALU_Control, code);
    chk("xor_ill", out_illegal, ill);
    tick();
    chk("xor_drain", out_valid, 0);

    // back-to-back I-type
    foreach (seq[k]) begin
      drive(2, seq[k], 0);
      #1 chk("b2b_in_ready", in_ready, 1);
      tick();
      ref_dec(2, seq[k], 0, code, ill, mul);
      chk("b2b_valid", out_valid, 1);
      chk("b2b_ctrl", ALU_Control, code);
    end
    in_valid = 0;
    tick();
    chk("b2b_drain", out_valid, 0);

    // DIV completing on 5th busy cycle
    drive(1, 0, 3);
    tick();
    in_valid = 0;
    out_ready = 0;
    #1 chk("div_in_ready", in_ready, 0);
    chk("div_mc_op", mc_op, 3);
    nb = 0; ns = 0; na = 0; ov_at = -1;
    for (int i = 0; i < 10; i++) begin
      if (busy) nb++;
      if (mc_start) ns++;
      if (mc_abort) na++;
      if (out_valid && ov_at < 0) ov_at = i;
      mc_done = (i == 4);
      tick();
    end
    mc_done = 0;
    chk("div_busy_cycles", nb, 5);
    chk("div_start_pulses", ns, 1);
    chk("div_abort_pulses", na, 0);
    chk("div_out_at", ov_at, 5);
    chk("div_ctrl", ALU_Control, 3);
    chk("div_timeout", out_timeout, 0);
    out_ready = 1;
    tick();
    chk("div_drain", out_valid, 0);

    // DIV that never completes
    drive(1, 0, 3);
    tick();
    in_valid = 0;
    out_ready = 0;
    nb = 0; na = 0; ab_at = -1; to_at = -1;
    for (int i = 0; i < 12; i++) begin
      if (busy) nb++;
      if (mc_abort) begin na++; if (ab_at < 0) ab_at = i; end
      if (out_timeout && to_at < 0) to_at = i;
      tick();
    end
    chk("to_busy_cycles", nb, 8);
    chk("to_abort_pulses", na, 1);
    chk("to_abort_at", ab_at, 8);
    chk("to_flag_at", to_at, 8);
    chk("to_valid", out_valid, 1);
    chk("to_ill", out_illegal, 0);
    out_ready = 1;
    tick();
    chk("to_drain", out_valid, 0);

    // illegal encodings and hold under backpressure
    drive(1, 0, 'h1F);
    tick();
    in_valid = 0;
    chk("ill_funct_flag", out_illegal, 1);
    chk("ill_funct_ctrl", ALU_Control, 0);
    tick();
    out_ready = 0;
    drive(3, 'h03, 0);
    tick();
    drive(2, 'h03, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_in_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_ill", out_illegal, 1);
      chk("hold_ctrl", ALU_Control, 0);
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    chk("hold_drain", out_valid, 0);

    // MULT flushed mid-flight, late done ignored
    drive(1, 0, 2);
    tick();
    in_valid = 0;
    chk("mult_busy", busy, 1);
    tick();
    flush = 1;
    drive(2, 'h05, 0);
    #1 chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 0;
    in_valid = 0;
    chk("flush_abort", mc_abort, 1);
    chk("flush_state", {busy, out_valid}, 0);
    mc_done = 1;
    tick();
    mc_done = 0;
    chk("flush_abort_once", mc_abort, 0);
    chk("late_done", {busy, out_valid}, 0);

    // reset in the middle of a multi-cycle op
    drive(1, 0, 4);
    tick();
    in_valid = 0;
    chk("mod_busy", busy, 1);
    reset = 1;
    tick();
    chk("rst_mid_mc", {busy, out_valid, mc_abort, mc_start}, 0);
    chk("rst_mid_ctrl", {ALU_Control, mc_op}, 0);
    reset = 0;
    tick();
    chk("rst_mid_abort", mc_abort, 0);

    // randomized single-cycle traffic vs. one-slot model
    pend = 0; exp_code = 0; exp_ill = 0;
    for (int i = 0; i < 400; i++) begin
      int a, o, f;
      a = $urandom_range(0, 3);
      o = $urandom_range(0, 31);
      f = $urandom_range(0, 15);
      ref_dec(a, o, f, code, ill, mul);
      if (mul) f = 0;
      ref_dec(a, o, f, code, ill, mul);
      drive(a, o, f);
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      ir = !pend || out_ready;
      #1 chk("rnd_in_ready", in_ready, ir);
      chk("rnd_valid", out_valid, pend);
      if (pend) begin
        chk("rnd_ctrl", ALU_Control, exp_code);
        chk("rnd_ill", out_illegal, exp_ill);
      end
      if (pend && out_ready) pend = 0;
      if (in_valid && ir) begin
        pend = 1;
        exp_code = code;
        exp_ill = ill;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
